// File: rtl/output_port_arbiter_pkg.sv
// rtl/output_port_arbiter_pkg.sv - shared constants, packet and state types for the output port arbiter
package output_port_arbiter_pkg;

    localparam int NUM_PORTS     = 4;
    localparam int BYTES_PER_PKT = 4;
    localparam int PKT_W         = 32;

    typedef logic [PKT_W-1:0] pkt_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/output_port_arbiter_rr_picker.sv
// rtl/output_port_arbiter_rr_picker.sv - combinational round-robin winner selection
//
// Purpose: picks the first set bit of eligible_i searching upward from
// ptr_i+1 with wrap, so the last winner (ptr_i) has lowest priority.
// Ports:
//   eligible_i  N      requesters allowed to win this cycle
//   ptr_i       IDX_W  index of the previous winner
//   winner_o    N      one-hot winner (zero when nothing eligible)
//   idx_o       IDX_W  winner index
//   any_o       1      at least one requester eligible
module rr_picker #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     eligible_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     winner_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    int j;

    always_comb begin
        winner_o = '0;
        idx_o    = '0;
        any_o    = 1'b0;
        j        = 0;
        for (int k = 1; k <= N; k++) begin
            j = (int'(ptr_i) + k) % N;
            if (!any_o && eligible_i[j]) begin
                any_o = 1'b1;
                idx_o = IDX_W'(j);
            end
        end
        if (any_o) begin
            winner_o[idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/output_port_arbiter.sv
// rtl/output_port_arbiter.sv - round-robin output port arbiter with byte serializer
//
// Purpose: arbitrates one router output port among NUM_IN input buffers,
// latches the winner's packet and sends it MSB byte first over the
// free_outbound/put_outbound handshake, then pulses grant to the winner.
// Ports:
//   clock             1              rising-edge clock
//   reset             1              synchronous active-high reset
//   req               NUM_IN         buffer i holds a packet for this port
//   req_data          NUM_IN*PKT     packet of buffer i at [i*PKT +: PKT]
//   free_outbound     1              node can accept a byte
//   put_outbound      1              payload_outbound valid
//   payload_outbound  8              outbound byte
//   grant             NUM_IN         one-cycle pulse: packet of buffer i sent
//   busy              1              in SEND or DONE
module output_port_arbiter #(
    parameter int NUM_IN        = output_port_arbiter_pkg::NUM_PORTS,
    parameter int BYTES_PER_PKT = output_port_arbiter_pkg::BYTES_PER_PKT,
    parameter int PORTID        = 0
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_IN-1:0]               req,
    input  logic [NUM_IN*8*BYTES_PER_PKT-1:0] req_data,
    input  logic                            free_outbound,
    output logic                            put_outbound,
    output logic [7:0]                      payload_outbound,
    output logic [NUM_IN-1:0]               grant,
    output logic                            busy
);
    import output_port_arbiter_pkg::*;

    localparam int W     = 8 * BYTES_PER_PKT;
    localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam int CNT_W = $clog2(BYTES_PER_PKT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BYTES_PER_PKT - 1);

    // Port index is informational; kept visible for hierarchy inspection.
    logic unused_portid;
    assign unused_portid = (PORTID != 0);

    arb_state_t         state_q;
    logic               put_q;
    logic [7:0]         payload_q;
    logic [NUM_IN-1:0]  grant_q;
    logic               busy_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [IDX_W-1:0]   ptr_q;
    logic [IDX_W-1:0]   idx_q;
    logic [NUM_IN-1:0]  win_q;
    logic [W-1:0]       shreg_q;

    // A requester being granted this cycle still has req high; masking it
    // keeps the just-finished packet from being captured a second time.
    logic [NUM_IN-1:0]  eligible;
    logic [NUM_IN-1:0]  pick_winner;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;

    assign eligible = req & ~grant_q;

    rr_picker #(
        .N     (NUM_IN),
        .IDX_W (IDX_W)
    ) u_rr_picker (
        .eligible_i (eligible),
        .ptr_i      (ptr_q),
        .winner_o   (pick_winner),
        .idx_o      (pick_idx),
        .any_o      (pick_any)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            put_q     <= 1'b0;
            payload_q <= 8'h00;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            ptr_q     <= IDX_W'(NUM_IN - 1);
            idx_q     <= '0;
            win_q     <= '0;
            shreg_q   <= '0;
        end else begin
            put_q   <= 1'b0;
            grant_q <= '0;
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        shreg_q <= req_data[int'(pick_idx)*W +: W];
                        idx_q   <= pick_idx;
                        win_q   <= pick_winner;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SEND;
                    end
                end
                SEND: begin
                    // Without free_outbound everything holds, including payload.
                    if (free_outbound) begin
                        put_q     <= 1'b1;
                        payload_q <= shreg_q[W-1 -: 8];
                        shreg_q   <= shreg_q << 8;
                        cnt_q     <= cnt_q + 1'b1;
                        if (cnt_q == LAST) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    grant_q <= win_q;
                    ptr_q   <= idx_q;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign put_outbound     = put_q;
    assign payload_outbound = payload_q;
    assign grant            = grant_q;
    assign busy             = busy_q;

endmodule
